// File: rtl/nibble_serializer_pkg.sv
// nibble_serializer_pkg: frame constants shared by the serializer and the downstream detector.
package nibble_serializer_pkg;
    localparam int FRAME_W = 4;
    localparam logic [FRAME_W-1:0] PATTERN = 4'b0110;
    localparam logic [FRAME_W-1:0] FILL_FRAME = 4'b1111;
    localparam bit FILL_OK = (FILL_FRAME != PATTERN);
endpackage

// File: rtl/nibble_serializer_sync_fifo.sv
// sync_fifo: small frame FIFO with a registered ready that depends only on occupancy.
module sync_fifo
    import nibble_serializer_pkg::*;
#(
    parameter int WIDTH = FRAME_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q;
    logic             push, pop;

    assign push = wr_valid_i && ready_q;
    assign pop  = rd_en_i && (count_q != '0);

    always_comb begin
        count_d = (push && !pop) ? count_q + CW'(1) :
                  (pop && !push) ? count_q - CW'(1) : count_q;
    end

    // ready follows next-state occupancy, so a full FIFO only reopens the cycle after a pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ready_q <= count_d < CW'(DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign wr_ready_o = ready_q;
endmodule

// File: rtl/nibble_serializer.sv
// nibble_serializer: gap-free MSB-first frame serializer; empty slots carry FILL to keep detector alignment.
module nibble_serializer
    import nibble_serializer_pkg::*;
#(
    parameter int               WIDTH  = FRAME_W,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] FILL   = FILL_FRAME,
    parameter int               UCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              frame_start,
    output logic              fill_active,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);
    localparam int BW = $clog2(WIDTH);

    if (!FILL_OK || WIDTH != FRAME_W || FILL == PATTERN || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("nibble_serializer: invalid WIDTH/DEPTH/FILL configuration");
    end

    logic [WIDTH-1:0]  shreg_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              fill_q, underrun_q;
    logic [UCNT_W-1:0] ucnt_q;
    logic [WIDTH-1:0]  head;
    logic              empty, boundary;

    assign boundary = (bit_cnt_q == BW'(WIDTH - 1));

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_data_i  (in_data),
        .wr_valid_i (in_valid),
        .wr_ready_o (in_ready),
        .rd_en_i    (boundary),
        .rd_data_o  (head),
        .empty_o    (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q    <= FILL;
            bit_cnt_q  <= '0;
            fill_q     <= 1'b1;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else if (!boundary) begin
            shreg_q    <= {shreg_q[WIDTH-2:0], 1'b0};
            bit_cnt_q  <= bit_cnt_q + BW'(1);
            underrun_q <= 1'b0;
        end else begin
            bit_cnt_q  <= '0;
            shreg_q    <= empty ? FILL : head;
            fill_q     <= empty;
            underrun_q <= empty;
            if (empty && !(&ucnt_q)) ucnt_q <= ucnt_q + UCNT_W'(1);
        end
    end

    assign out_bit      = shreg_q[WIDTH-1];
    assign frame_start  = (bit_cnt_q == '0);
    assign fill_active  = fill_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;
endmodule

// File: tb/tb_nibble_serializer.sv
// tb_nibble_serializer: directed bench for the nibble serializer with hand-derived expectations.
module tb_nibble_serializer;
    import nibble_serializer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, out_bit, frame_start, fill_active, underrun;
    logic [7:0] underrun_cnt;

    int checks = 0;
    int errors = 0;

    nibble_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_bit      (out_bit),
        .frame_start  (frame_start),
        .fill_active  (fill_active),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        step;
        rst = 1'b0;
    endtask

    logic [3:0]  burst [4];
    logic [20:0] got;
    logic [8:0]  rdy_exp;
    logic [4:0]  match;
    logic [7:0]  seq;
    logic        acc, all_ones;
    int          idx;

    initial begin
        // idle after reset: FILL frames, underrun pulse after every boundary
        do_reset;
        chk("rst_out_bit", out_bit, 1);
        chk("rst_frame_start", frame_start, 1);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fill", fill_active, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_ucnt", underrun_cnt, 0);
        for (int i = 0; i < 12; i++) begin
            chk("idle_bit", out_bit, 1);
            chk("idle_fs", frame_start, (i % 4) == 0);
            chk("idle_ur", underrun, (i % 4) == 0 && i > 0);
            step;
        end
        chk("idle_ucnt", underrun_cnt, 3);
        chk("idle_ur12", underrun, 1);

        // single push in cycle 1 streams in cycles 4..7
        do_reset;
        step;
        in_data = 4'b0110;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        step;
        for (int i = 0; i < 4; i++) begin
            chk("single_bit", out_bit, (4'b0110 >> (3 - i)) & 1);
            chk("single_fill", fill_active, 0);
            chk("single_fs", frame_start, i == 0);
            step;
        end
        chk("single_fill_after", fill_active, 1);
        chk("single_ur_after", underrun, 1);
        chk("single_ucnt", underrun_cnt, 1);

        // burst with backpressure
        burst[0] = 4'b0110;
        burst[1] = 4'b1010;
        burst[2] = 4'b0011;
        burst[3] = 4'b0110;
        rdy_exp = 9'b100010011;
        do_reset;
        idx = 0;
        in_data = burst[0];
        in_valid = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            got[20-c] = out_bit;
            if (c >= 4 && c < 20) chk("burst_fill", fill_active, 0);
            if (c <= 8) chk("burst_ready", in_ready, rdy_exp[c]);
            acc = in_valid && in_ready;
            step;
            if (acc) begin
                idx++;
                if (idx == 4) in_valid = 1'b0;
                else in_data = burst[idx];
            end
        end
        chk("burst_accepted", idx, 4);
        chk("burst_stream", got, 21'b1111_0110_1010_0011_0110_1);
        for (int s = 0; s < 5; s++) match[s] = (got[20-4*s -: 4] == PATTERN);
        chk("burst_match", match, 5'b10010);

        // push coinciding with a boundary pop at count=1
        do_reset;
        in_data = 4'b1010;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        step;
        chk("coinc_ready_c3", in_ready, 1);
        in_data = 4'b0011;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        chk("coinc_ready_c4", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            seq[7-i] = out_bit;
            if (i == 4) chk("coinc_no_ur", underrun, 0);
            step;
        end
        chk("coinc_stream", seq, 8'b1010_0011);
        chk("coinc_ur_end", underrun, 1);
        chk("coinc_ucnt", underrun_cnt, 1);

        // reset mid-frame with two frames queued
        do_reset;
        in_data = 4'b0110;
        in_valid = 1'b1;
        step;
        in_data = 4'b0101;
        step;
        in_valid = 1'b0;
        step;
        step;
        chk("mid_ready_c4", in_ready, 1);
        in_data = 4'b0011;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        chk("mid_bit2", out_bit, 1);
        chk("mid_fs", frame_start, 0);
        chk("mid_ready_c6", in_ready, 0);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("mid_rst_bit", out_bit, 1);
        chk("mid_rst_fs", frame_start, 1);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_ucnt", underrun_cnt, 0);
        chk("mid_rst_fill", fill_active, 1);
        all_ones = 1'b1;
        for (int i = 0; i < 12; i++) begin
            all_ones &= out_bit & fill_active;
            step;
        end
        chk("mid_flushed", all_ones, 1);
        chk("mid_ucnt", underrun_cnt, 3);

        // underrun counter saturation
        do_reset;
        repeat (1016) step;
        chk("sat_254", underrun_cnt, 254);
        repeat (4) step;
        chk("sat_255", underrun_cnt, 255);
        repeat (180) step;
        chk("sat_hold", underrun_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serializer.md
Name: nibble_serializer

Overview:
- Upstream feeder for the serial 4-bit frame sequence detector.
- Accepts parallel frames over a valid/ready handshake, buffers them in a small FIFO, and drives one bit per clock, MSB first, with no gaps.
- The detector has no valid qualifier and checks fixed 4-bit frame slots, so the block never stalls the bit stream. On underrun it emits a FILL frame that cannot match, which keeps frame alignment.
- Also reports frame boundaries and counts underruns.

Parameters:
- WIDTH, 4: frame width in bits; must equal the detector frame length.
- DEPTH, 2: FIFO entries, power of two, at least 2.
- FILL, 4'b1111: frame emitted when the FIFO is empty at a frame boundary; must never equal the detected pattern.
- UCNT_W, 8: underrun counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  WIDTH  parallel frame, bit WIDTH-1 sent first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a frame; registered, depends only on FIFO occupancy.
- out_bit  out  1  serial bit to the detector's inBit; changes only on clk edges.
- frame_start  out  1  high while out_bit carries bit WIDTH-1 of a frame.
- fill_active  out  1  the current frame slot carries FILL, not user data.
- underrun  out  1  one-cycle pulse when a FILL frame is loaded.
- underrun_cnt  out  UCNT_W  saturating count of FILL loads.

Behaviour:
- State:
  - shreg[WIDTH-1:0]: shift register.
  - bit_cnt: 0..WIDTH-1.
  - FIFO: DEPTH entries, with wr_ptr, rd_ptr and count (0..DEPTH).
  - fill_active, underrun, underrun_cnt: registers.
- Reset (rst=1 at an edge):
  - shreg=FILL, bit_cnt=0, FIFO empty, in_ready=1, fill_active=1, underrun=0, underrun_cnt=0.
  - Consequence: out_bit=FILL[WIDTH-1] and frame_start=1 in the first cycle after reset.
  - Reset mid-frame discards the partial frame and all FIFO contents.
  - The system releases the detector's reset on the same edge, so both blocks align to slot 0.
- Outputs: out_bit = shreg[WIDTH-1]; frame_start = (bit_cnt==0).
- Per edge with rst=0:
  - If bit_cnt < WIDTH-1: shreg shifts left by one (zero into LSB), bit_cnt+1.
  - If bit_cnt == WIDTH-1 (frame boundary): bit_cnt=0.
    - FIFO count>0: shreg=FIFO head, pop, fill_active=0, underrun=0.
    - FIFO empty: shreg=FILL, fill_active=1, underrun=1, underrun_cnt+1 (saturates at all-ones).
  - underrun is 0 on every non-boundary edge.
- Push: in_valid && in_ready writes in_data at wr_ptr. Both pointers wrap modulo DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- No bypass. A frame pushed at edge t is loadable at the first boundary edge after t, never at t itself.
  - With an empty FIFO, latency from push edge to its first bit on out_bit is 1..WIDTH+... bounded by WIDTH cycles after the next boundary. Exactly: the frame appears at the next boundary edge strictly after t.
- in_ready = (count < DEPTH) as registered next-state. While count==DEPTH, in_ready=0 even if a pop happens that cycle; space frees on the following cycle.
- in_valid while in_ready=0 is ignored; the source holds the data.
- Sustained throughput: one frame per WIDTH cycles. A source pushing faster sees backpressure; no data is lost or reordered.

Decomposition:
- Shared package:
  - FRAME_W=4.
  - Pattern constant PATTERN=4'b0110, shared with the detector.
  - FILL_FRAME=4'b1111.
  - Compile-time check FILL_FRAME != PATTERN.
- One sub-module: sync_fifo (DEPTH x WIDTH, count, full/empty, registered ready). The serializer top holds the shift register, bit counter and underrun logic.

Test Plan:
- Reset, then no input for 12 cycles -> out_bit=1 every cycle, frame_start at cycles 0,4,8, underrun pulses at edges 3,7,11, underrun_cnt=3.
- Push 4'b0110 at cycle 1 with the FIFO idle -> bits 0,1,1,0 in cycles 4-7, frame_start at cycle 4, fill_active=0 in cycles 4-7. A chained detector asserts out in cycle 8.
- Burst-push 0110, 1010, 0011, 0110 with in_valid held high -> in_ready drops after 2 accepted frames, all 16 bits emerge in order with no FILL between them, and the detector matches frames 1 and 4 only.
- Push on the same edge as a boundary pop with count=1 -> count stays 1, the popped frame streams next, the pushed frame follows with no underrun.
- Assert rst during bit 2 of a data frame with 2 frames queued -> next cycle out_bit=1, frame_start=1, in_ready=1, underrun_cnt=0, queued frames never emitted.
- Starve for 300 frames -> underrun_cnt saturates at 255 and does not wrap.
